reconfig_image_sequencer: RTL and testbench
===========================================

# reconfig_image_sequencer

Controller that drives the FPGA internal-reconfiguration port (cfg_CBSEL, cfg_ENA, cfg_CONFIG) from the golden image. It turns a debounced push-button or a software request into a protocol-correct image-select / enable / config-pulse sequence. It watches cfg_ERROR and a timeout to detect a failed switch, and reports its state on the board LEDs. It sits between the golden top level's button/LED pins and the configuration-control pins.

## Interface
- SETUP_CYC, 16: cycles cfg_CBSEL/cfg_ENA are held stable before the config pulse (≥1).
- PULSE_CYC, 4: width of the cfg_CONFIG pulse in cycles (≥1).
- TIMEOUT_CYC, 1024: cycles to wait after the pulse before declaring failure (≥1).
- DEBOUNCE_CYC, 65536: cycles the synchronized button must stay stable before it is accepted (≥1). Benches override it to a small value.
- clk  input  1  reconfiguration clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- btn  input  1  raw asynchronous push-button; pressed = 1.
- sw_req  input  1  synchronous one-cycle request pulse.
- image_sel  input  2  target image index, sampled when a request is accepted.
- clr  input  1  synchronous clear; exits FAIL.
- cfg_ERROR  input  1  configuration error from the device; level, synchronous to clk.
- cfg_CBSEL  output  2  image select to the configuration block.
- cfg_ENA  output  1  reconfiguration enable.
- cfg_CONFIG  output  1  reconfiguration trigger pulse.
- busy  output  1  high in SETUP, PULSE and HOLD.
- err  output  1  sticky failure flag.
- err_timeout  output  1  high with err when the failure cause was the timeout.
- led  output  4  status: one-hot {FAIL, HOLD, PULSE, SETUP}; 0000 in IDLE.

## Operation
- Reset value of all outputs: 0. State: IDLE. The debounce filter clears to the released state.
- Button path: 2-FF synchronizer, then a stability counter. The debounced level changes only after DEBOUNCE_CYC consecutive cycles at the new synchronized value. A debounced 0→1 transition produces a one-cycle btn_req.
- The request is `btn_req | sw_req`. It is accepted only in IDLE; in every other state it is dropped, not queued.
- States:
  - IDLE: on request, latch image_sel into cfg_CBSEL → SETUP.
  - SETUP: cfg_ENA=1 and cfg_CBSEL held; lasts SETUP_CYC cycles → PULSE.
  - PULSE: cfg_ENA=1, cfg_CONFIG=1; lasts PULSE_CYC cycles → HOLD.
  - HOLD: cfg_ENA=1, cfg_CONFIG=0. The counter runs to TIMEOUT_CYC, then go to FAIL with err_timeout=1. A successful switch reloads the device, so HOLD normally never exits.
  - FAIL: cfg_ENA=0, cfg_CONFIG=0, cfg_CBSEL keeps its last value, err=1. On clr → IDLE, with err and err_timeout cleared in the same edge.
- cfg_ERROR=1 in SETUP, PULSE or HOLD → FAIL on the next edge with err_timeout=0. cfg_ERROR is ignored in IDLE and FAIL.
- A single shared counter (width clog2 of the largest of SETUP_CYC, PULSE_CYC, TIMEOUT_CYC) clears on every state entry.
- cfg_CBSEL changes only on IDLE→SETUP, so it is stable for the entire ENA window.

## Timing
- Request accepted at edge N: cfg_CBSEL and cfg_ENA are valid after edge N. cfg_CONFIG rises after edge N+SETUP_CYC and falls after edge N+SETUP_CYC+PULSE_CYC.
- Timeout: FAIL is entered at edge N+SETUP_CYC+PULSE_CYC+TIMEOUT_CYC.
- Button latency from a clean press to request: 2 (sync) + DEBOUNCE_CYC cycles, ±1.
- Simultaneous events:
  - cfg_ERROR and a counter terminal count on the same cycle: FAIL wins, err_timeout=0.
  - clr and cfg_ERROR in FAIL: go to IDLE.
  - btn_req and sw_req together: a single request.
- rst mid-sequence: all outputs go to 0 on that edge, including cfg_CONFIG mid-pulse. The sequence is not resumed.
- Button bounce shorter than DEBOUNCE_CYC produces no request. Holding the button produces exactly one request.

## Test plan
- DEBOUNCE_CYC=8, image_sel=2, btn held high 20 cycles → cfg_CBSEL=2 and cfg_ENA=1 about 10 cycles after press. cfg_CONFIG high for exactly 4 cycles, starting 16 cycles after ENA.
- sw_req pulse, no cfg_ERROR → HOLD for 1024 cycles, then FAIL with err=1, err_timeout=1, led=1000, cfg_ENA=0. clr → IDLE with all flags 0.
- cfg_ERROR asserted on the 2nd PULSE cycle → next cycle cfg_CONFIG=0, cfg_ENA=0, err=1, err_timeout=0.
- btn toggling every 3 cycles for 50 cycles with DEBOUNCE_CYC=8 → no request. A second sw_req during SETUP → ignored; cfg_CBSEL unchanged.
- rst asserted during PULSE → cfg_CONFIG, cfg_ENA, cfg_CBSEL and led all 0 on the next cycle. A new sw_req then gives a full normal sequence.

Source files
------------

// File: rtl/reconfig_image_sequencer.sv
// reconfig_image_sequencer
// Drives the device internal-reconfiguration port from the golden image.
// A debounced button press or a software pulse starts an image-select /
// enable / config-pulse sequence. A failed switch is detected through
// cfg_ERROR or a post-pulse timeout.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   btn           raw asynchronous push-button (pressed = 1)
//   sw_req        one-cycle software request
//   image_sel     target image, latched when a request is accepted
//   clr           leaves FAIL and clears the error flags
//   cfg_ERROR     configuration error level from the device
//   cfg_CBSEL     image select (changes only on IDLE->SETUP)
//   cfg_ENA       reconfiguration enable (SETUP, PULSE, HOLD)
//   cfg_CONFIG    reconfiguration trigger (PULSE)
//   busy          high in SETUP, PULSE and HOLD
//   err           sticky failure flag
//   err_timeout   failure was caused by the timeout
//   led           one-hot {FAIL, HOLD, PULSE, SETUP}, 0000 in IDLE
module reconfig_image_sequencer #(
   parameter int SETUP_CYC    = 16,
   parameter int PULSE_CYC    = 4,
   parameter int TIMEOUT_CYC  = 1024,
   parameter int DEBOUNCE_CYC = 65536
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn,
   input  logic       sw_req,
   input  logic [1:0] image_sel,
   input  logic       clr,
   input  logic       cfg_ERROR,
   output logic [1:0] cfg_CBSEL,
   output logic       cfg_ENA,
   output logic       cfg_CONFIG,
   output logic       busy,
   output logic       err,
   output logic       err_timeout,
   output logic [3:0] led
);

   localparam int MAX_AB  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
   localparam int MAX_CYC = (MAX_AB > TIMEOUT_CYC) ? MAX_AB : TIMEOUT_CYC;
   localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam int DW      = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

   localparam logic [CW-1:0] SETUP_LAST   = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] PULSE_LAST   = CW'(PULSE_CYC - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);
   localparam logic [DW-1:0] DB_LAST      = DW'(DEBOUNCE_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_PULSE = 3'd2,
      S_HOLD  = 3'd3,
      S_FAIL  = 3'd4
   } state_t;

   logic [1:0]    sync_r;
   logic          db_level_r;
   logic [DW-1:0] db_cnt_r;
   logic          btn_req_r;

   state_t        state_r, state_nxt;
   logic [CW-1:0] cnt_r, cnt_nxt;
   logic [1:0]    cbsel_nxt;
   logic          err_nxt, err_to_nxt;
   logic          req_s;

   // Button synchronizer, stability filter and rising-edge request pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_r     <= 2'b00;
         db_level_r <= 1'b0;
         db_cnt_r   <= '0;
         btn_req_r  <= 1'b0;
      end else begin
         sync_r    <= {sync_r[0], btn};
         btn_req_r <= 1'b0;
         if (sync_r[1] == db_level_r) begin
            db_cnt_r <= '0;
         end else if (db_cnt_r == DB_LAST) begin
            // New level has been stable long enough; a press raises a request
            db_level_r <= sync_r[1];
            db_cnt_r   <= '0;
            btn_req_r  <= sync_r[1];
         end else begin
            db_cnt_r <= db_cnt_r + DW'(1);
         end
      end
   end

   assign req_s = btn_req_r | sw_req;

   // Next-state logic; cfg_ERROR outranks a terminal count on the same cycle
   always_comb begin
      state_nxt  = state_r;
      cbsel_nxt  = cfg_CBSEL;
      err_nxt    = err;
      err_to_nxt = err_timeout;
      case (state_r)
         S_IDLE: begin
            if (req_s) begin
               state_nxt = S_SETUP;
               cbsel_nxt = image_sel;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_SETUP, S_PULSE, S_HOLD: begin
            if (cfg_ERROR) begin
               state_nxt  = S_FAIL;
               err_nxt    = 1'b1;
               err_to_nxt = 1'b0;
            end else if (state_r == S_SETUP && cnt_r == SETUP_LAST) begin
               state_nxt = S_PULSE;
            end else if (state_r == S_PULSE && cnt_r == PULSE_LAST) begin
               state_nxt = S_HOLD;
            end else if (state_r == S_HOLD && cnt_r == TIMEOUT_LAST) begin
               state_nxt  = S_FAIL;
               err_nxt    = 1'b1;
               err_to_nxt = 1'b1;
            end else begin
               state_nxt = state_r;
            end
         end
         S_FAIL: begin
            if (clr) begin
               state_nxt  = S_IDLE;
               err_nxt    = 1'b0;
               err_to_nxt = 1'b0;
            end else begin
               state_nxt = S_FAIL;
            end
         end
         default: begin
            state_nxt  = S_IDLE;
            err_nxt    = 1'b0;
            err_to_nxt = 1'b0;
         end
      endcase

      // Shared counter restarts on every state entry and idles at zero
      if (state_nxt != state_r || state_nxt == S_IDLE || state_nxt == S_FAIL) begin
         cnt_nxt = '0;
      end else begin
         cnt_nxt = cnt_r + CW'(1);
      end
   end

   // State, counter and all outputs registered from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= S_IDLE;
         cnt_r       <= '0;
         cfg_CBSEL   <= 2'b00;
         cfg_ENA     <= 1'b0;
         cfg_CONFIG  <= 1'b0;
         busy        <= 1'b0;
         err         <= 1'b0;
         err_timeout <= 1'b0;
         led         <= 4'b0000;
      end else begin
         state_r     <= state_nxt;
         cnt_r       <= cnt_nxt;
         cfg_CBSEL   <= cbsel_nxt;
         cfg_ENA     <= (state_nxt == S_SETUP) || (state_nxt == S_PULSE) || (state_nxt == S_HOLD);
         cfg_CONFIG  <= (state_nxt == S_PULSE);
         busy        <= (state_nxt == S_SETUP) || (state_nxt == S_PULSE) || (state_nxt == S_HOLD);
         err         <= err_nxt;
         err_timeout <= err_to_nxt;
         led         <= {state_nxt == S_FAIL, state_nxt == S_HOLD,
                         state_nxt == S_PULSE, state_nxt == S_SETUP};
      end
   end

endmodule

// File: tb/tb_reconfig_image_sequencer.sv
// Directed testbench for reconfig_image_sequencer (DEBOUNCE_CYC = 8).
module tb_reconfig_image_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn = 1'b0;
   logic       sw_req = 1'b0;
   logic [1:0] image_sel = 2'd0;
   logic       clr = 1'b0;
   logic       cfg_ERROR = 1'b0;
   logic [1:0] cfg_CBSEL;
   logic       cfg_ENA, cfg_CONFIG, busy, err, err_timeout;
   logic [3:0] led;
   wire [10:0] all_out = {cfg_CBSEL, cfg_ENA, cfg_CONFIG, busy, err, err_timeout, led};

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reconfig_image_sequencer #(
      .SETUP_CYC(16), .PULSE_CYC(4), .TIMEOUT_CYC(1024), .DEBOUNCE_CYC(8)
   ) dut (
      .clk(clk), .rst(rst), .btn(btn), .sw_req(sw_req), .image_sel(image_sel),
      .clr(clr), .cfg_ERROR(cfg_ERROR), .cfg_CBSEL(cfg_CBSEL), .cfg_ENA(cfg_ENA),
      .cfg_CONFIG(cfg_CONFIG), .busy(busy), .err(err), .err_timeout(err_timeout), .led(led)
   );

   // Advance n rising edges; outputs are examined 1 time unit after each edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      checks++;
      if (all_out !== 11'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected %b", all_out, 11'd0);
      end
   endtask

   task automatic test_button();
      int k = 0;
      int hi = 1;
      bit found = 1'b0;
      image_sel = 2'd2;
      btn = 1'b1;
      for (int i = 1; i <= 30 && !found; i++) begin
         step(1);
         if (cfg_ENA === 1'b1) begin
            found = 1'b1;
            k = i;
         end
      end
      checks++;
      if (!found || k < 10 || k > 12) begin
         errors++;
         $display("FAIL btn_latency: got %0d cycles (found=%0d) expected 10..12", k, found);
      end
      checks++;
      if (cfg_CBSEL !== 2'd2 || led !== 4'b0001 || busy !== 1'b1) begin
         errors++;
         $display("FAIL btn_setup: got cbsel=%0d led=%b busy=%b expected cbsel=2 led=0001 busy=1",
                  cfg_CBSEL, led, busy);
      end
      for (int i = 1; i <= 16; i++) begin
         step(1);
         if (i == 9) btn = 1'b0;
         if (i == 15) begin
            checks++;
            if (cfg_CONFIG !== 1'b0) begin
               errors++;
               $display("FAIL config_early: got %b expected 0", cfg_CONFIG);
            end
         end
      end
      checks++;
      if (cfg_CONFIG !== 1'b1 || led !== 4'b0010) begin
         errors++;
         $display("FAIL config_rise: got config=%b led=%b expected config=1 led=0010", cfg_CONFIG, led);
      end
      for (int i = 1; i <= 4; i++) begin
         step(1);
         if (cfg_CONFIG === 1'b1) hi++;
      end
      checks++;
      if (hi !== 4 || led !== 4'b0100 || cfg_ENA !== 1'b1) begin
         errors++;
         $display("FAIL pulse_width: got width=%0d led=%b ena=%b expected width=4 led=0100 ena=1",
                  hi, led, cfg_ENA);
      end
      cfg_ERROR = 1'b1;
      step(1);
      cfg_ERROR = 1'b0;
      checks++;
      if (led !== 4'b1000 || err !== 1'b1 || err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL hold_error: got led=%b err=%b to=%b expected led=1000 err=1 to=0",
                  led, err, err_timeout);
      end
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      step(12);
      checks++;
      if (all_out !== {2'd2, 9'd0}) begin
         errors++;
         $display("FAIL btn_clr_idle: got %b expected %b", all_out, {2'd2, 9'd0});
      end
   endtask

   task automatic test_timeout();
      image_sel = 2'd1;
      sw_req = 1'b1;
      step(1);
      sw_req = 1'b0;
      checks++;
      if (cfg_ENA !== 1'b1 || cfg_CBSEL !== 2'd1 || led !== 4'b0001) begin
         errors++;
         $display("FAIL sw_accept: got ena=%b cbsel=%0d led=%b expected ena=1 cbsel=1 led=0001",
                  cfg_ENA, cfg_CBSEL, led);
      end
      step(20);
      checks++;
      if (led !== 4'b0100 || cfg_CONFIG !== 1'b0) begin
         errors++;
         $display("FAIL hold_entry: got led=%b config=%b expected led=0100 config=0", led, cfg_CONFIG);
      end
      step(1023);
      checks++;
      if (led !== 4'b0100 || err !== 1'b0) begin
         errors++;
         $display("FAIL hold_last: got led=%b err=%b expected led=0100 err=0", led, err);
      end
      step(1);
      checks++;
      if (all_out !== {2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1000}) begin
         errors++;
         $display("FAIL timeout_fail: got %b expected %b", all_out,
                  {2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1000});
      end
      sw_req = 1'b1;
      step(1);
      sw_req = 1'b0;
      checks++;
      if (led !== 4'b1000 || err !== 1'b1) begin
         errors++;
         $display("FAIL fail_drops_req: got led=%b err=%b expected led=1000 err=1", led, err);
      end
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      checks++;
      if (all_out !== {2'd1, 9'd0}) begin
         errors++;
         $display("FAIL timeout_clr: got %b expected %b", all_out, {2'd1, 9'd0});
      end
   endtask

   task automatic test_error_pulse();
      image_sel = 2'd3;
      sw_req = 1'b1;
      step(1);
      sw_req = 1'b0;
      step(17);
      checks++;
      if (cfg_CONFIG !== 1'b1 || led !== 4'b0010) begin
         errors++;
         $display("FAIL pulse_second: got config=%b led=%b expected config=1 led=0010", cfg_CONFIG, led);
      end
      cfg_ERROR = 1'b1;
      step(1);
      checks++;
      if (all_out !== {2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1000}) begin
         errors++;
         $display("FAIL pulse_error: got %b expected %b", all_out,
                  {2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1000});
      end
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      checks++;
      if (led !== 4'b0000 || err !== 1'b0) begin
         errors++;
         $display("FAIL clr_with_error: got led=%b err=%b expected led=0000 err=0", led, err);
      end
      step(2);
      cfg_ERROR = 1'b0;
      checks++;
      if (all_out !== {2'd3, 9'd0}) begin
         errors++;
         $display("FAIL idle_ignores_error: got %b expected %b", all_out, {2'd3, 9'd0});
      end
   endtask

   task automatic test_bounce();
      bit saw_busy = 1'b0;
      image_sel = 2'd0;
      for (int i = 0; i < 50; i++) begin
         btn = ((i / 3) % 2) == 1;
         step(1);
         if (cfg_ENA !== 1'b0 || busy !== 1'b0) saw_busy = 1'b1;
      end
      btn = 1'b0;
      step(12);
      if (cfg_ENA !== 1'b0 || busy !== 1'b0) saw_busy = 1'b1;
      checks++;
      if (saw_busy !== 1'b0 || cfg_CBSEL !== 2'd3) begin
         errors++;
         $display("FAIL bounce: got busy_seen=%b cbsel=%0d expected busy_seen=0 cbsel=3",
                  saw_busy, cfg_CBSEL);
      end
   endtask

   task automatic test_back_to_back();
      image_sel = 2'd1;
      sw_req = 1'b1;
      step(1);
      image_sel = 2'd2;
      step(1);
      sw_req = 1'b0;
      checks++;
      if (cfg_CBSEL !== 2'd1 || led !== 4'b0001) begin
         errors++;
         $display("FAIL setup_drops_req: got cbsel=%0d led=%b expected cbsel=1 led=0001", cfg_CBSEL, led);
      end
      step(14);
      checks++;
      if (cfg_CONFIG !== 1'b0) begin
         errors++;
         $display("FAIL setup_no_restart_early: got config=%b expected 0", cfg_CONFIG);
      end
      step(1);
      checks++;
      if (cfg_CONFIG !== 1'b1 || cfg_CBSEL !== 2'd1) begin
         errors++;
         $display("FAIL setup_no_restart: got config=%b cbsel=%0d expected config=1 cbsel=1",
                  cfg_CONFIG, cfg_CBSEL);
      end
      cfg_ERROR = 1'b1;
      step(1);
      cfg_ERROR = 1'b0;
      clr = 1'b1;
      step(1);
      clr = 1'b0;
   endtask

   task automatic test_reset_mid();
      image_sel = 2'd2;
      sw_req = 1'b1;
      step(1);
      sw_req = 1'b0;
      step(17);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      checks++;
      if (all_out !== 11'd0) begin
         errors++;
         $display("FAIL reset_mid_pulse: got %b expected %b", all_out, 11'd0);
      end
      step(3);
      checks++;
      if (all_out !== 11'd0) begin
         errors++;
         $display("FAIL reset_no_resume: got %b expected %b", all_out, 11'd0);
      end
      image_sel = 2'd3;
      sw_req = 1'b1;
      step(1);
      sw_req = 1'b0;
      checks++;
      if (cfg_ENA !== 1'b1 || cfg_CBSEL !== 2'd3) begin
         errors++;
         $display("FAIL post_reset_accept: got ena=%b cbsel=%0d expected ena=1 cbsel=3", cfg_ENA, cfg_CBSEL);
      end
      step(16);
      checks++;
      if (cfg_CONFIG !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_pulse: got %b expected 1", cfg_CONFIG);
      end
      step(4);
      checks++;
      if (cfg_CONFIG !== 1'b0 || led !== 4'b0100) begin
         errors++;
         $display("FAIL post_reset_hold: got config=%b led=%b expected config=0 led=0100", cfg_CONFIG, led);
      end
   endtask

   task automatic test_error_at_timeout();
      step(1023);
      cfg_ERROR = 1'b1;
      step(1);
      cfg_ERROR = 1'b0;
      checks++;
      if (led !== 4'b1000 || err !== 1'b1 || err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL error_beats_timeout: got led=%b err=%b to=%b expected led=1000 err=1 to=0",
                  led, err, err_timeout);
      end
      clr = 1'b1;
      step(1);
      clr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_button();
      test_timeout();
      test_error_pulse();
      test_bounce();
      test_back_to_back();
      test_reset_mid();
      test_error_at_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
